// File: rtl/shape_edge_seq.sv
// shape_edge_seq: takes one decoded draw opcode and emits its edges one per
// valid/ready handshake as {start, end} vertex pairs for the rasteriser.
// Optional build macro SEQ_SKIP_DEGENERATE_EN: zero-length non-circle edges are
// dropped (one silent EMIT cycle each) instead of being emitted.
module shape_edge_seq #(
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 9,
    parameter int unsigned MAX_VERTS = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_VERTS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [1:0]                       op_kind,
    input  logic [CNT_W-1:0]                 op_nverts,
    input  logic [MAX_VERTS*(X_W+Y_W)-1:0]   op_verts,
    input  logic [15:0]                      op_color,
    input  logic                             op_fill,
    output logic                             seg_valid,
    input  logic                             seg_ready,
    output logic [X_W+Y_W-1:0]               seg_start,
    output logic [X_W+Y_W-1:0]               seg_end,
    output logic                             seg_circ,
    output logic [CNT_W-1:0]                 seg_idx,
    output logic [15:0]                      seg_color,
    output logic                             seg_fill,
    output logic                             op_done,
    output logic                             op_err
);

    localparam int unsigned PW = X_W + Y_W;

    localparam logic [1:0] KindLine = 2'd0;
    localparam logic [1:0] KindPoly = 2'd1;
    localparam logic [1:0] KindCirc = 2'd2;
    localparam logic [1:0] KindRsvd = 2'd3;

    typedef enum logic [1:0] {StIdle, StEmit, StDone} state_t;

    state_t                    state;
    logic [MAX_VERTS*PW-1:0]   verts_q;
    logic [CNT_W-1:0]          nedges_q;

    logic                      op_legal;
    logic [CNT_W-1:0]          op_edges;
    logic [PW-1:0]             first_start;
    logic [PW-1:0]             first_end;
    logic                      first_valid;
    logic [CNT_W-1:0]          nxt_idx;
    logic [CNT_W-1:0]          end_idx;
    logic [PW-1:0]             nxt_start;
    logic [PW-1:0]             nxt_end;
    logic                      nxt_valid;
    logic                      last_edge;
    logic                      advance;

    // Select vertex i from the packed vertex bus; out-of-range indices give 0.
    function automatic logic [PW-1:0] vert_at(input logic [MAX_VERTS*PW-1:0] v,
                                              input logic [CNT_W-1:0] i);
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_VERTS; k++) begin
            if (CNT_W'(k) == i) r = v[k*PW +: PW];
        end
        return r;
    endfunction

    // Opcode legality, edge count and the endpoints of the next edge.
    always_comb begin
        op_legal = 1'b1;
        if (op_kind == KindRsvd) begin
            op_legal = 1'b0;
        end else if (op_kind == KindPoly &&
                     (op_nverts < CNT_W'(3) || op_nverts > CNT_W'(MAX_VERTS))) begin
            op_legal = 1'b0;
        end
        op_edges    = (op_kind == KindPoly) ? op_nverts : CNT_W'(1);
        first_start = op_verts[PW-1:0];
        first_end   = op_verts[2*PW-1:PW];
        nxt_idx     = seg_idx + CNT_W'(1);
        // Closing edge of a polygon wraps its end vertex back to v0.
        end_idx     = (nxt_idx + CNT_W'(1) == nedges_q) ? '0 : nxt_idx + CNT_W'(1);
        nxt_start   = vert_at(verts_q, nxt_idx);
        nxt_end     = vert_at(verts_q, end_idx);
        last_edge   = (seg_idx == nedges_q - CNT_W'(1));
`ifdef SEQ_SKIP_DEGENERATE_EN
        // A suppressed edge sits in EMIT with seg_valid low and advances regardless.
        advance     = seg_ready || !seg_valid;
        first_valid = (op_kind == KindCirc) || (first_start != first_end);
        nxt_valid   = (nxt_start != nxt_end);
`else
        advance     = seg_ready;
        first_valid = 1'b1;
        nxt_valid   = 1'b1;
`endif
    end

    // Sequencer FSM; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            verts_q   <= '0;
            nedges_q  <= '0;
            op_ready  <= 1'b1;
            seg_valid <= 1'b0;
            seg_start <= '0;
            seg_end   <= '0;
            seg_circ  <= 1'b0;
            seg_idx   <= '0;
            seg_color <= '0;
            seg_fill  <= 1'b0;
            op_done   <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            op_done <= 1'b0;
            op_err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (op_valid) begin
                        verts_q   <= op_verts;
                        nedges_q  <= op_edges;
                        op_ready  <= 1'b0;
                        seg_color <= op_color;
                        seg_fill  <= op_fill;
                        seg_circ  <= (op_kind == KindCirc);
                        seg_idx   <= '0;
                        // Edge 0 is v0->v1 for every legal kind.
                        seg_start <= first_start;
                        seg_end   <= first_end;
                        if (op_legal) begin
                            state     <= StEmit;
                            seg_valid <= first_valid;
                        end else begin
                            state   <= StDone;
                            op_err  <= 1'b1;
                            op_done <= 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (advance) begin
                        if (last_edge) begin
                            state     <= StDone;
                            seg_valid <= 1'b0;
                            op_done   <= 1'b1;
                        end else begin
                            seg_idx   <= nxt_idx;
                            seg_start <= nxt_start;
                            seg_end   <= nxt_end;
                            seg_valid <= nxt_valid;
                        end
                    end
                end
                StDone: begin
                    state    <= StIdle;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= StIdle;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

    // KindLine is implicit in the edge-count default; named here for readability.
    logic unused_kind_line;
    assign unused_kind_line = (KindLine == 2'd0);

endmodule

// File: tb/tb_shape_edge_seq.sv
// Scoreboard bench for shape_edge_seq: a reference model expands each opcode into
// its expected edge list; a negedge monitor checks every presented segment.
module tb_shape_edge_seq;

    localparam int X_W       = 10;
    localparam int Y_W       = 9;
    localparam int MAX_VERTS = 4;
    localparam int CNT_W     = 3;
    localparam int PW        = X_W + Y_W;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        op_valid = 1'b0;
    logic                        op_ready;
    logic [1:0]                  op_kind = '0;
    logic [CNT_W-1:0]            op_nverts = '0;
    logic [MAX_VERTS*PW-1:0]     op_verts = '0;
    logic [15:0]                 op_color = '0;
    logic                        op_fill = 1'b0;
    logic                        seg_valid;
    logic                        seg_ready = 1'b0;
    logic [PW-1:0]               seg_start;
    logic [PW-1:0]               seg_end;
    logic                        seg_circ;
    logic [CNT_W-1:0]            seg_idx;
    logic [15:0]                 seg_color;
    logic                        seg_fill;
    logic                        op_done;
    logic                        op_err;

    shape_edge_seq #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .MAX_VERTS(MAX_VERTS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_kind  (op_kind),
        .op_nverts(op_nverts),
        .op_verts (op_verts),
        .op_color (op_color),
        .op_fill  (op_fill),
        .seg_valid(seg_valid),
        .seg_ready(seg_ready),
        .seg_start(seg_start),
        .seg_end  (seg_end),
        .seg_circ (seg_circ),
        .seg_idx  (seg_idx),
        .seg_color(seg_color),
        .seg_fill (seg_fill),
        .op_done  (op_done),
        .op_err   (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]    s;
        logic [PW-1:0]    e;
        logic             circ;
        logic [CNT_W-1:0] idx;
        logic [15:0]      color;
        logic             fill;
    } seg_t;

    seg_t          exp_q[$];
    seg_t          mon_x;
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            mon_en  = 1'b0;
    logic [PW-1:0] cur_v [MAX_VERTS];

    function automatic logic [PW-1:0] mk(input int x, input int y);
        logic [X_W-1:0] xx;
        logic [Y_W-1:0] yy;
        xx = X_W'(x);
        yy = Y_W'(y);
        return {xx, yy};
    endfunction

    // Monitor: whatever the DUT presents must equal the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && seg_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_seg: got idx=%0d start=%h end=%h, required no segment",
                         seg_idx, seg_start, seg_end);
            end else begin
                mon_x = exp_q[0];
                if (seg_start !== mon_x.s || seg_end !== mon_x.e || seg_circ !== mon_x.circ ||
                    seg_idx !== mon_x.idx || seg_color !== mon_x.color ||
                    seg_fill !== mon_x.fill) begin
                    n_fail++;
                    $display("FAIL seg_check: got idx=%0d start=%h end=%h circ=%0b col=%h fill=%0b, required idx=%0d start=%h end=%h circ=%0b col=%h fill=%0b",
                             seg_idx, seg_start, seg_end, seg_circ, seg_color, seg_fill,
                             mon_x.idx, mon_x.s, mon_x.e, mon_x.circ, mon_x.color, mon_x.fill);
                end
                if (seg_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Reference model: expand an opcode into its edge list from the shape rules.
    // Returns the number of EMIT cycles at full speed (0 for an illegal opcode).
    task automatic model(input logic [1:0] kind, input int n, input logic [15:0] color,
                         input bit fill, output int nedges, output bit legal);
        seg_t x;
        legal  = (kind != 2'd3) && !(kind == 2'd1 && (n < 3 || n > MAX_VERTS));
        nedges = !legal ? 0 : (kind == 2'd1 ? n : 1);
        for (int i = 0; i < nedges; i++) begin
            x.s     = cur_v[i];
            x.e     = (kind == 2'd1) ? cur_v[(i + 1) % n] : cur_v[1];
            x.circ  = (kind == 2'd2);
            x.idx   = CNT_W'(i);
            x.color = color;
            x.fill  = fill;
`ifdef SEQ_SKIP_DEGENERATE_EN
            if (!x.circ && x.s == x.e) continue;
`endif
            exp_q.push_back(x);
        end
    endtask

    // mode 0: always ready; 1: random; 2: pattern 1,0,0,1,0,0...
    function automatic logic ready_draw(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return ((c - 1) % 3) == 0;
    endfunction

    task automatic scramble_inputs();
        op_kind   = 2'($urandom);
        op_nverts = CNT_W'($urandom);
        for (int i = 0; i < MAX_VERTS; i++) op_verts[i*PW +: PW] = PW'($urandom);
        op_color  = 16'($urandom);
        op_fill   = 1'($urandom);
    endtask

    task automatic run_op(input logic [1:0] kind, input int n, input logic [15:0] color,
                          input bit fill, input int mode);
        int nedges;
        bit legal;
        bit got;
        int done_c;
        bit err_at_done;
        model(kind, n, color, fill, nedges, legal);
        @(posedge clk);
        #1;
        op_kind   = kind;
        op_nverts = CNT_W'(n);
        for (int i = 0; i < MAX_VERTS; i++) op_verts[i*PW +: PW] = cur_v[i];
        op_color  = color;
        op_fill   = fill;
        op_valid  = 1'b1;
        seg_ready = 1'($urandom_range(0, 1));
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            if (op_ready === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("accept_ready", {31'd0, got}, 32'd1);
        if (!got) begin
            op_valid = 1'b0;
            exp_q.delete();
            return;
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        scramble_inputs();
        done_c      = 0;
        err_at_done = 1'b0;
        for (int c = 1; c <= 300 && done_c == 0; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            seg_ready = ready_draw(mode, c);
            @(negedge clk);
            check("ready_low_busy", {31'd0, op_ready}, 32'd0);
            if (op_done === 1'b1) begin
                done_c      = c;
                err_at_done = op_err;
            end else if (op_err !== 1'b0) begin
                check("err_without_done", {31'd0, op_err}, 32'd0);
            end
        end
        check("done_seen", {31'd0, done_c != 0}, 32'd1);
        if (mode == 0) check("done_time", 32'(done_c), 32'(nedges + 1));
        check("err_flag", {31'd0, err_at_done}, {31'd0, !legal});
        @(posedge clk);
        #1;
        seg_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("ready_after_done", {30'd0, op_ready, op_done}, 32'd2);
        check("all_edges_out", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        seg_t x;
        bit   got;
        int   k;
        int   n;
        // Reset and reset-state checks.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_seg_valid", {31'd0, seg_valid}, 32'd0);
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_done_err", {30'd0, op_done, op_err}, 32'd0);
        check("rst_seg_idx", 32'(seg_idx), 32'd0);
        check("rst_start_end", {seg_start[12:0], seg_end}, 32'd0);
        check("rst_start_hi", 32'(seg_start), 32'd0);
        check("rst_color", {seg_color, 14'd0, seg_circ, seg_fill}, 32'd0);
        mon_en = 1'b1;

        // LINE (10,5)->(20,7).
        cur_v[0] = mk(10, 5); cur_v[1] = mk(20, 7); cur_v[2] = mk(1, 1); cur_v[3] = mk(2, 2);
        run_op(2'd0, 0, 16'hF800, 1'b0, 0);
        // Triangle.
        cur_v[0] = mk(0, 0); cur_v[1] = mk(8, 0); cur_v[2] = mk(0, 8); cur_v[3] = mk(3, 3);
        run_op(2'd1, 3, 16'h07E0, 1'b1, 0);
        // Quad with stall pattern.
        cur_v[0] = mk(1, 2); cur_v[1] = mk(30, 4); cur_v[2] = mk(33, 40); cur_v[3] = mk(5, 44);
        run_op(2'd1, 4, 16'h001F, 1'b0, 2);
        // Circle center (100,50), radius (0,12).
        cur_v[0] = mk(100, 50); cur_v[1] = mk(0, 12); cur_v[2] = mk(0, 0); cur_v[3] = mk(0, 0);
        run_op(2'd2, 0, 16'hABCD, 1'b1, 0);
        // Illegal: POLY n=2, POLY n=5, reserved kind.
        run_op(2'd1, 2, 16'h1234, 1'b0, 0);
        run_op(2'd1, 5, 16'h1234, 1'b0, 0);
        run_op(2'd3, 4, 16'h4321, 1'b1, 0);
        // Degenerate middle edge (v1==v2): suppressed only when the skip build is used.
        cur_v[0] = mk(0, 0); cur_v[1] = mk(9, 9); cur_v[2] = mk(9, 9); cur_v[3] = mk(7, 7);
        run_op(2'd1, 3, 16'h5555, 1'b0, 0);

        // Reset mid-shape right after edge 1 of a triangle.
        cur_v[0] = mk(0, 0); cur_v[1] = mk(8, 0); cur_v[2] = mk(0, 8);
        x.circ = 1'b0; x.color = 16'hBEEF; x.fill = 1'b1;
        x.s = mk(0, 0); x.e = mk(8, 0); x.idx = 3'd0; exp_q.push_back(x);
        x.s = mk(8, 0); x.e = mk(0, 8); x.idx = 3'd1; exp_q.push_back(x);
        @(posedge clk);
        #1;
        op_kind = 2'd1; op_nverts = 3'd3; op_color = 16'hBEEF; op_fill = 1'b1;
        for (int i = 0; i < MAX_VERTS; i++) op_verts[i*PW +: PW] = cur_v[i];
        op_valid = 1'b1; seg_ready = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            if (op_ready === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_seg_valid", {31'd0, seg_valid}, 32'd0);
        check("midrst_op_ready", {31'd0, op_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            check("midrst_no_done", {30'd0, op_done, seg_valid}, 32'd0);
            @(negedge clk);
        end
        check("midrst_edges", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Randomised opcodes with random downstream back-pressure.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < MAX_VERTS; i++) begin
                if ($urandom_range(0, 3) == 0) cur_v[i] = mk($urandom_range(0, 1), $urandom_range(0, 1));
                else cur_v[i] = PW'($urandom);
            end
            k = $urandom_range(0, 9);
            n = $urandom_range(0, 7);
            run_op((k < 6) ? 2'd1 : 2'($urandom_range(0, 3)), n, 16'($urandom), 1'($urandom),
                   $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shape_edge_seq.md
# shape_edge_seq

Parametrised successor to the opcode splitter. It accepts one decoded draw opcode (color, shape kind, up to MAX_VERTS vertices, fill flag) over a valid/ready handshake, then emits that shape's edges one per handshake, as {start, end} location pairs, to the rasteriser. It sits between the opcode decoder and the line/circle rasteriser, so the rasteriser no longer needs an external output-select counter.

## Interface
- X_W, 10: x coordinate width.
- Y_W, 9: y coordinate width; a vertex is PW = X_W+Y_W bits, {x,y}, x in the MSBs.
- MAX_VERTS, 4: maximum polygon vertex count; legal range 3..8.
- CNT_W, $clog2(MAX_VERTS+1): width of the vertex-count and index fields.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- op_valid  in  1  opcode present.
- op_ready  out  1  block can accept an opcode.
- op_kind  in  2  shape kind: 0 LINE, 1 POLY, 2 CIRCLE, 3 reserved.
- op_nverts  in  CNT_W  vertex count; used for POLY only.
- op_verts  in  MAX_VERTS*PW  packed vertices; vertex i is at [i*PW +: PW].
- op_color  in  16  RGB565 color.
- op_fill  in  1  fill flag, passed through.
- seg_valid  out  1  segment present.
- seg_ready  in  1  downstream accepts the segment.
- seg_start, seg_end  out  PW each  segment endpoints; for CIRCLE these are center and radius.
- seg_circ  out  1  segment is a circle descriptor.
- seg_idx  out  CNT_W  edge index within the shape.
- seg_color  out  16  latched color.
- seg_fill  out  1  latched fill flag.
- op_done  out  1  one-cycle pulse when the shape has finished.
- op_err  out  1  one-cycle pulse when an opcode is rejected as illegal.

## Operation
- States: IDLE, EMIT, DONE.
- IDLE: op_ready=1. When op_valid is high, the block latches all op_* fields into internal registers and validates them.
  - Legal opcode: edge index cleared to 0, next state EMIT.
  - Illegal opcode (kind 3, or POLY with nverts<3 or nverts>MAX_VERTS): op_err pulses, next state DONE.
- Edge count and edge i by kind:
  - LINE: 1 edge, v0→v1.
  - CIRCLE: 1 descriptor, {v0, v1}, with seg_circ=1.
  - POLY with n vertices: n edges; edge i is v[i]→v[(i+1) mod n]. The last edge closes the polygon, v[n-1]→v0.
- EMIT:
  - seg_valid=1 and the seg_* outputs hold edge idx.
  - The outputs stay stable while seg_ready=0.
  - When seg_ready is high: if idx is the last edge, the block goes to DONE; otherwise idx increments.
- DONE: op_done pulses for exactly 1 cycle, next state IDLE.
- Outputs come directly from registers (latched fields, idx, state). No combinational path from op_* to seg_*.
- Reset values: state IDLE, seg_valid 0, op_done 0, op_err 0, seg_idx 0, seg_start, seg_end and seg_color all 0, seg_circ 0, seg_fill 0. op_ready reads 1 in the first cycle after reset.
- Reset mid-shape: the block abandons the shape at once, with no op_done and no further segments.

## Timing
- Accept at edge T:
  - seg_valid is high from T+1 with edge 0.
  - op_ready is 0 from T+1 until the cycle after DONE.
- With seg_ready held at 1, an n-edge shape gives:
  - seg_valid for n consecutive cycles, T+1..T+n;
  - op_done at T+n+1;
  - op_ready at T+n+2.
- Every shape therefore costs n+2 cycles; the single bubble between shapes is intentional.
- Illegal opcode accepted at T: op_err at T+1 (in DONE, alongside op_done), op_ready at T+2.
- seg_ready asserted while seg_valid=0 has no effect. op_valid is ignored outside IDLE.
- Vertex select uses the modulo wrap from n-1 to 0. Index arithmetic is CNT_W wide, so no overflow is possible within the legal range.

## Configuration
- SEQ_SKIP_DEGENERATE_EN
  - Defined: any non-circle edge with start==end is suppressed. It costs one cycle in EMIT with seg_valid=0, then idx advances.
  - If every edge is degenerate, no segment is emitted; op_done still pulses.
  - seg_idx still reports the true edge index, so emitted indices may have gaps.
- Undefined: every edge is emitted, zero-length ones included. Cycle counts are exactly as in Timing.

## Test plan
- LINE v0=(10,5), v1=(20,7), seg_ready=1 → one segment start=(10,5), end=(20,7), seg_circ=0, idx 0, at T+1; op_done at T+2.
- POLY n=3 with v0=(0,0), v1=(8,0), v2=(0,8) → edges (0,0)→(8,0), (8,0)→(0,8), (0,8)→(0,0), idx 0,1,2, on consecutive cycles; op_done at T+4.
- POLY n=4 with seg_ready toggled 1,0,0,1,… → seg_* stay stable while stalled, and no edge is lost or duplicated.
- CIRCLE center=(100,50), radius=(0,12) → a single segment with seg_circ=1, start=(100,50), end=(0,12).
- POLY n=2, then kind=3 → op_err pulse and no seg_valid for each; op_ready returns 2 cycles after each accept.
- POLY n=3 mid-shape with rst=1 for 1 cycle after edge 1 → seg_valid=0 and op_ready=1 the next cycle, with no op_done. With SEQ_SKIP_DEGENERATE_EN defined, v1==v2 → the edge at idx 1 is suppressed and idx 0 and idx 2 are emitted.
